// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states, default widths.
package alu_pkg;

    localparam int ALU_WIDTH   = 8;
    localparam int ALU_SHAMT_W = 4;
    localparam int ALU_CNT_W   = 4;

    localparam logic [ALU_CNT_W-1:0] ALU_MUL_STEPS = 4'd8;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_SHIFT = 2'd2
    } alu_state_t;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier datapath, one partial product per step; lower WIDTH bits kept.
// Only built when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;

    // Next accumulator value; exposed so the final step lands on RESULT in the same edge.
    always_comb begin
        if (mplier_r[0]) begin
            acc_next = acc_r + mcand_r;
        end else begin
            acc_next = acc_r;
        end
    end

    // Operand registers: load at launch, advance one bit per step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
        end else if (load) begin
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= a;
            mplier_r <= b;
        end else if (step) begin
            acc_r    <= acc_next;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
        end else begin
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
        end
    end

endmodule
`endif

// File: rtl/alu_multicycle.sv
// 8-bit ALU: single-cycle FWD/ADD/AND/OR, iterative shifts and (with ALU_MUL_EN) shift-add MUL.
// Without ALU_MUL_EN the MUL opcode completes in one cycle with a zero result.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    input  logic             START,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    alu_state_t             state_r;
    logic [2:0]             op_r;
    logic [ALU_CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]       sh_r;
    logic [WIDTH-1:0]       result_r;
    logic                   busy_r;
    logic                   done_r;

    logic [SHAMT_W-1:0]     shamt_s;
    logic [ALU_CNT_W-1:0]   shift_len_s;
    logic [WIDTH-1:0]       single_s;
    logic [WIDTH-1:0]       sh_next_s;
    logic [WIDTH-1:0]       mul_next_s;
    logic                   launch_s;
    logic                   is_mul_s;
    logic                   is_long_shift_s;

    assign shamt_s  = DATA2[SHAMT_W-1:0];
    assign launch_s = (state_r == ST_IDLE) && START;

`ifdef ALU_MUL_EN
    localparam logic MUL_EN = 1'b1;
    logic mul_load_s;
    logic mul_step_s;

    assign mul_load_s = launch_s && (SELECT == ALU_MUL);
    assign mul_step_s = (state_r == ST_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk      (CLK),
        .rst_n    (RESET),
        .load     (mul_load_s),
        .step     (mul_step_s),
        .a        (DATA1),
        .b        (DATA2),
        .acc_next (mul_next_s)
    );
`else
    localparam logic MUL_EN = 1'b0;
    assign mul_next_s = {WIDTH{1'b0}};
`endif

    assign is_mul_s        = MUL_EN && (SELECT == ALU_MUL);
    assign is_long_shift_s = is_shift_op(SELECT) && (shamt_s != 4'd0);

    // Shift distances of 8 or more saturate to 8 single-bit steps.
    always_comb begin
        if (shamt_s >= 4'd8) begin
            shift_len_s = 4'd8;
        end else begin
            shift_len_s = shamt_s;
        end
    end

    // Single-cycle result; zero-distance shifts forward operand A.
    always_comb begin
        single_s = {WIDTH{1'b0}};
        case (SELECT)
            ALU_FWD: single_s = DATA1;
            ALU_ADD: single_s = DATA1 + DATA2;
            ALU_AND: single_s = DATA1 & DATA2;
            ALU_OR:  single_s = DATA1 | DATA2;
            ALU_MUL: single_s = {WIDTH{1'b0}};
            ALU_SLL, ALU_SRL, ALU_SRA: single_s = DATA1;
            default: single_s = {WIDTH{1'b0}};
        endcase
    end

    // One-bit shift step on the working register.
    always_comb begin
        sh_next_s = sh_r;
        case (op_r)
            ALU_SLL: sh_next_s = {sh_r[WIDTH-2:0], 1'b0};
            ALU_SRL: sh_next_s = {1'b0, sh_r[WIDTH-1:1]};
            ALU_SRA: sh_next_s = {sh_r[WIDTH-1], sh_r[WIDTH-1:1]};
            default: sh_next_s = sh_r;
        endcase
    end

    // Control FSM with registered RESULT/BUSY/DONE.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r  <= ST_IDLE;
            op_r     <= ALU_FWD;
            cnt_r    <= 4'd0;
            sh_r     <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        op_r <= SELECT;
                        sh_r <= DATA1;
                        if (is_mul_s) begin
                            state_r <= ST_MUL;
                            cnt_r   <= ALU_MUL_STEPS;
                            busy_r  <= 1'b1;
                        end else if (is_long_shift_s) begin
                            state_r <= ST_SHIFT;
                            cnt_r   <= shift_len_s;
                            busy_r  <= 1'b1;
                        end else begin
                            result_r <= single_s;
                            done_r   <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (cnt_r == 4'd1) begin
                        result_r <= mul_next_s;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_SHIFT: begin
                    // Last step goes straight to RESULT so intermediates stay hidden.
                    if (cnt_r == 4'd1) begin
                        result_r <= sh_next_s;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        sh_r  <= sh_next_s;
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign RESULT = result_r;
    assign BUSY   = busy_r;
    assign DONE   = done_r;
    assign ZERO   = (result_r == {WIDTH{1'b0}});

endmodule
